// File: rtl/output_scaler_pipe.sv
// Three-stage per-channel requantiser: multiply, round/shift, saturate.
// Define OSCALER_ZERO_POINT_EN to add a per-channel zero point (cfg_zp).
module output_scaler_pipe #(
    parameter int numElements    = 4,
    parameter int elementWidth   = 20,
    parameter int outputWidth    = 8,
    parameter int fixedPointBits = 16,
    parameter int shiftBits      = 5,
    parameter int numChannels    = 16,
    parameter int satCntWidth    = 16
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [numElements*elementWidth-1:0] wx_i,
    input  logic [$clog2(numChannels)-1:0]      chan_i,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [numElements*outputWidth-1:0]  y_o,
    input  logic                                cfg_we,
    input  logic [$clog2(numChannels)-1:0]      cfg_addr,
    input  logic [fixedPointBits-1:0]           cfg_scale,
    input  logic [shiftBits-1:0]                cfg_shift,
`ifdef OSCALER_ZERO_POINT_EN
    input  logic [outputWidth-1:0]              cfg_zp,
`endif
    input  logic                                cfg_round,
    input  logic                                sat_clr,
    output logic [satCntWidth-1:0]              sat_cnt
);
    localparam int EW   = elementWidth;
    localparam int OW   = outputWidth;
    localparam int PW   = EW + 1 + fixedPointBits;
    localparam int PW1  = PW + 1;
    localparam int QW   = PW1 - fixedPointBits;
    localparam int RW   = QW + 1;
    localparam int ZW   = RW + 1;
    localparam int NW   = $clog2(numElements + 1);
    localparam int SCW1 = satCntWidth + 1;
    localparam logic signed [ZW-1:0] MAXV = ZW'((1 << (OW - 1)) - 1);
    localparam logic signed [ZW-1:0] MINV = ~MAXV;

    function automatic logic [EW:0] mag_f(input logic [EW-1:0] w);
        logic [EW:0] x;
        x = {w[EW-1], w};
        return w[EW-1] ? -x : x;
    endfunction

    // s never drops below fixedPointBits, so the rounding half is always >= bit 15
    function automatic logic [QW-1:0] rshift_f(input logic [PW-1:0] p,
                                               input logic [shiftBits-1:0] sh,
                                               input logic rnd);
        logic [7:0]   s;
        logic [PW1-1:0] half;
        logic [PW1-1:0] ext;
        s = 8'(fixedPointBits) + 8'(sh);
        if (s >= 8'(PW))
            return (rnd && s == 8'(PW)) ? QW'(p[PW-1]) : '0;
        half = rnd ? (PW1'(1) << (s - 8'd1)) : '0;
        ext  = {1'b0, p} + half;
        return QW'(ext >> s);
    endfunction

    logic [fixedPointBits-1:0] scale_q [numChannels];
    logic [shiftBits-1:0]      shift_q [numChannels];
`ifdef OSCALER_ZERO_POINT_EN
    logic [OW-1:0]             zp_q    [numChannels];
`endif

    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int c = 0; c < numChannels; c++) begin
                scale_q[c] <= '0;
                shift_q[c] <= '0;
`ifdef OSCALER_ZERO_POINT_EN
                zp_q[c]    <= '0;
`endif
            end
        end else if (cfg_we) begin
            scale_q[cfg_addr] <= cfg_scale;
            shift_q[cfg_addr] <= cfg_shift;
`ifdef OSCALER_ZERO_POINT_EN
            zp_q[cfg_addr]    <= cfg_zp;
`endif
        end
    end

    logic                    v1_q, v2_q, v3_q;
    logic [PW-1:0]           p1_d  [numElements];
    logic [PW-1:0]           p1_q  [numElements];
    logic                    sg1_d [numElements];
    logic                    sg1_q [numElements];
    logic [shiftBits-1:0]    sh1_d [numElements];
    logic [shiftBits-1:0]    sh1_q [numElements];
    logic signed [RW-1:0]    r2_d  [numElements];
    logic signed [RW-1:0]    r2_q  [numElements];
    logic signed [ZW-1:0]    t3    [numElements];
    logic [OW-1:0]           zp1_d [numElements];
    logic [OW-1:0]           zp1_q [numElements];
    logic [OW-1:0]           zp2_q [numElements];
    logic [numElements*OW-1:0] y_d, y_q;
    logic [NW-1:0]           nsat;
    logic [satCntWidth-1:0]  sat_cnt_d, sat_cnt_q;
    logic [SCW1-1:0]         cnt_sum;

    always_comb begin
        for (int e = 0; e < numElements; e++) begin
            sg1_d[e] = wx_i[e*EW + EW-1];
            p1_d[e]  = PW'(mag_f(wx_i[e*EW +: EW]))
                     * PW'(scale_q[chan_i + $clog2(numChannels)'(e)]);
            sh1_d[e] = shift_q[chan_i + $clog2(numChannels)'(e)];
`ifdef OSCALER_ZERO_POINT_EN
            zp1_d[e] = zp_q[chan_i + $clog2(numChannels)'(e)];
`else
            zp1_d[e] = '0;
`endif
        end
    end

    always_comb begin
        for (int e = 0; e < numElements; e++) begin
            r2_d[e] = RW'(rshift_f(p1_q[e], sh1_q[e], cfg_round));
            if (sg1_q[e])
                r2_d[e] = -r2_d[e];
        end
    end

    // zero point joins in full width so the clamp sees the true sum
    always_comb begin
        y_d  = '0;
        nsat = '0;
        for (int e = 0; e < numElements; e++) begin
            t3[e] = $signed({r2_q[e][RW-1], r2_q[e]})
                  + $signed({{(ZW-OW){zp2_q[e][OW-1]}}, zp2_q[e]});
            if (t3[e] > MAXV) begin
                y_d[e*OW +: OW] = {1'b0, {(OW-1){1'b1}}};
                nsat = nsat + NW'(1);
            end else if (t3[e] < MINV) begin
                y_d[e*OW +: OW] = {1'b1, {(OW-1){1'b0}}};
                nsat = nsat + NW'(1);
            end else begin
                y_d[e*OW +: OW] = t3[e][OW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            y_q  <= '0;
            for (int e = 0; e < numElements; e++) begin
                p1_q[e]  <= '0;
                sg1_q[e] <= 1'b0;
                sh1_q[e] <= '0;
                zp1_q[e] <= '0;
                zp2_q[e] <= '0;
                r2_q[e]  <= '0;
            end
        end else if (en) begin
            v1_q <= in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            y_q  <= y_d;
            for (int e = 0; e < numElements; e++) begin
                p1_q[e]  <= p1_d[e];
                sg1_q[e] <= sg1_d[e];
                sh1_q[e] <= sh1_d[e];
                zp1_q[e] <= zp1_d[e];
                zp2_q[e] <= zp1_q[e];
                r2_q[e]  <= r2_d[e];
            end
        end
    end

    assign cnt_sum = {1'b0, sat_cnt_q} + SCW1'(nsat);

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr)
            sat_cnt_d = '0;
        else if (en && v2_q)
            sat_cnt_d = cnt_sum[satCntWidth] ? '1 : cnt_sum[satCntWidth-1:0];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            sat_cnt_q <= '0;
        else
            sat_cnt_q <= sat_cnt_d;
    end

    assign out_valid = v3_q;
    assign y_o       = y_q;
    assign sat_cnt   = sat_cnt_q;
endmodule

// File: tb/tb_output_scaler_pipe.sv
// Scoreboard bench for output_scaler_pipe: directed scenarios plus
// an in-order check of every output vector against a table mirror.
module tb_output_scaler_pipe;
    localparam int NE = 4;
    localparam int EW = 20;
    localparam int OW = 8;
    localparam int NC = 16;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NE*EW-1:0]  wx_i = '0;
    logic [3:0]        chan_i = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [NE*OW-1:0]  y_o;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_addr = '0;
    logic [15:0]       cfg_scale = '0;
    logic [4:0]        cfg_shift = '0;
`ifdef OSCALER_ZERO_POINT_EN
    logic [7:0]        cfg_zp = '0;
`endif
    logic              cfg_round = 1'b0;
    logic              sat_clr = 1'b0;
    logic [15:0]       sat_cnt;

    output_scaler_pipe dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready),
        .wx_i(wx_i), .chan_i(chan_i),
        .out_valid(out_valid), .out_ready(out_ready), .y_o(y_o),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
`ifdef OSCALER_ZERO_POINT_EN
        .cfg_zp(cfg_zp),
`endif
        .cfg_round(cfg_round), .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int acc_cnt = 0;
    int rx_cnt  = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_y;
    int m_scale [NC];
    int m_shift [NC];

    function automatic logic [79:0] pack4(input int a, input int b,
                                          input int c, input int d);
        return {20'(d), 20'(c), 20'(b), 20'(a)};
    endfunction

    function automatic logic [31:0] model(input logic [79:0] w,
                                          input logic [3:0] ch,
                                          input logic rnd);
        logic [31:0] r;
        logic signed [19:0] ws;
        longint x, mag, prod, q, v;
        int idx, s;
        r = '0;
        for (int e = 0; e < NE; e++) begin
            ws   = w[e*EW +: EW];
            x    = longint'(ws);
            mag  = (x < 0) ? -x : x;
            idx  = (int'(ch) + e) % NC;
            prod = mag * longint'(m_scale[idx]);
            s    = 16 + m_shift[idx];
            if (rnd) q = (prod + (longint'(1) << (s - 1))) >> s;
            else     q = prod >> s;
            v = (x < 0) ? -q : q;
            if (v > 127)       v = 127;
            else if (v < -128) v = -128;
            r[e*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (nrst) begin
            if (out_valid && out_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_extra: got %h expected no output", y_o);
                end else begin
                    exp_y = sb.pop_front();
                    if (y_o !== exp_y) begin
                        errors++;
                        $display("FAIL sb_data: got %h expected %h", y_o, exp_y);
                    end
                end
                rx_cnt++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(wx_i, chan_i, cfg_round));
                acc_cnt++;
            end
            if (cfg_we) begin
                m_scale[cfg_addr] = int'(cfg_scale);
                m_shift[cfg_addr] = int'(cfg_shift);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int a, input int sc, input int sh);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(a);
        cfg_scale = 16'(sc);
        cfg_shift = 5'(sh);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse_clr();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
    endtask

    task automatic send1(input logic [79:0] w, input logic [3:0] ch,
                         output logic [31:0] y, output int lat);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        wx_i      = w;
        chan_i    = ch;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        y = y_o;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors += 3;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b expected 0", out_valid);
        end
        if (y_o !== 32'h0) begin
            errors++; $display("FAIL rst_y: got %h expected 0", y_o);
        end
        if (sat_cnt !== 16'h0) begin
            errors++; $display("FAIL rst_satcnt: got %h expected 0", sat_cnt);
        end
        nrst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready: got %b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] y;
        int lat;
        cfg_round = 1'b0;
        cfg_write(0, 'h8000, 1);
        send1(pack4(100, 0, 0, 0), 4'd0, y, lat);
        vectors += 2;
        if (lat != 3) begin
            errors++; $display("FAIL latency: got %0d expected 3", lat);
        end
        if (y[7:0] !== 8'd25) begin
            errors++; $display("FAIL basic_pos: got %h expected 19", y[7:0]);
        end
        send1(pack4(-102, 0, 0, 0), 4'd0, y, lat);
        vectors++;
        if (y[7:0] !== 8'hE7) begin
            errors++; $display("FAIL basic_trunc_neg: got %h expected e7", y[7:0]);
        end
        tick();
        cfg_round = 1'b1;
        send1(pack4(-102, 0, 0, 0), 4'd0, y, lat);
        vectors++;
        if (y[7:0] !== 8'hE6) begin
            errors++; $display("FAIL basic_round_neg: got %h expected e6", y[7:0]);
        end
        send1(pack4(0, 0, 0, 0), 4'd0, y, lat);
        vectors++;
        if (y !== 32'h0) begin
            errors++; $display("FAIL basic_zero: got %h expected 0", y);
        end
        tick();
        cfg_round = 1'b0;
    endtask

    task automatic test_saturation();
        logic [31:0] y;
        int lat;
        for (int a = 4; a < 8; a++) cfg_write(a, 'hFFFF, 0);
        pulse_clr();
        send1(pack4(1000, -1000, 5, -5), 4'd4, y, lat);
        vectors += 2;
        if (y !== 32'hFC04807F) begin
            errors++; $display("FAIL sat_values: got %h expected fc04807f", y);
        end
        if (sat_cnt !== 16'd2) begin
            errors++; $display("FAIL sat_cnt1: got %0d expected 2", sat_cnt);
        end
        send1(pack4(1000, -1000, 5, -5), 4'd4, y, lat);
        vectors++;
        if (sat_cnt !== 16'd4) begin
            errors++; $display("FAIL sat_cnt2: got %0d expected 4", sat_cnt);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        vectors += 2;
        if (sat_cnt !== 16'd0) begin
            errors++; $display("FAIL sat_clr_race: got %0d expected 0", sat_cnt);
        end
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL sat_clr_valid: got %b expected 1", out_valid);
        end
        tick();
        vectors++;
        if (sat_cnt !== 16'd0) begin
            errors++; $display("FAIL sat_clr_hold: got %0d expected 0", sat_cnt);
        end
    endtask

    task automatic test_sticky();
        pulse_clr();
        out_ready = 1'b1;
        wx_i      = pack4(1000, -1000, 1000, -1000);
        chan_i    = 4'd4;
        in_valid  = 1'b1;
        repeat (16400) tick();
        in_valid = 1'b0;
        repeat (5) tick();
        vectors++;
        if (sat_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL sat_sticky: got %h expected ffff", sat_cnt);
        end
    endtask

    task automatic test_channel_map();
        logic [31:0] y;
        int lat;
        cfg_write(14, 'h4000, 0);
        cfg_write(15, 'h8000, 0);
        cfg_write(0,  'hC000, 0);
        cfg_write(1,  'h2000, 0);
        send1(pack4(64, 64, 64, 64), 4'd14, y, lat);
        vectors++;
        if (y !== 32'h08302010) begin
            errors++; $display("FAIL chan_wrap: got %h expected 08302010", y);
        end
        tick();
    endtask

    task automatic test_write_race();
        logic [31:0] y1, y2;
        int lat;
        cfg_write(3, 'h4000, 0);
        out_ready = 1'b1;
        cfg_we    = 1'b1;
        cfg_addr  = 4'd3;
        cfg_scale = 16'h8000;
        cfg_shift = 5'd0;
        in_valid  = 1'b1;
        wx_i      = pack4(40, 0, 0, 0);
        chan_i    = 4'd3;
        tick();
        cfg_we = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        y1 = y_o;
        tick();
        y2 = y_o;
        vectors += 2;
        if (y1[7:0] !== 8'd10) begin
            errors++; $display("FAIL race_old: got %0d expected 10", y1[7:0]);
        end
        if (y2[7:0] !== 8'd20) begin
            errors++; $display("FAIL race_new: got %0d expected 20", y2[7:0]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int base, rbase, last;
        bit stall;
        logic [31:0] ys;
        cfg_round = 1'b1;
        for (int a = 8; a < 12; a++)
            cfg_write(a, int'($urandom_range(1, 'hFFFF)), int'($urandom_range(0, 3)));
        base  = acc_cnt;
        rbase = rx_cnt;
        last  = acc_cnt;
        stall = 1'b0;
        ys    = '0;
        chan_i   = 4'd8;
        in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (stall) begin
                vectors++;
                if (y_o !== ys || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold: got %h/%b expected %h/1", y_o, out_valid, ys);
                end
            end
            if (acc_cnt - base >= 10) begin
                in_valid = 1'b0;
            end else if (!in_valid || acc_cnt != last) begin
                in_valid = 1'($urandom_range(0, 1));
                wx_i = 80'({$urandom(), $urandom(), $urandom()});
            end
            last      = acc_cnt;
            out_ready = 1'($urandom_range(0, 1));
            stall     = out_valid && !out_ready;
            ys        = y_o;
            if (acc_cnt - base >= 10 && rx_cnt - rbase >= 10) break;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        vectors += 3;
        if (acc_cnt - base != 10) begin
            errors++; $display("FAIL bp_sent: got %0d expected 10", acc_cnt - base);
        end
        if (rx_cnt - rbase != 10) begin
            errors++; $display("FAIL bp_recv: got %0d expected 10", rx_cnt - rbase);
        end
        if (sb.size() != 0) begin
            errors++; $display("FAIL bp_leftover: got %0d expected 0", sb.size());
        end
        cfg_round = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [31:0] y;
        int lat;
        pulse_clr();
        out_ready = 1'b1;
        wx_i      = pack4(1000, 0, 0, 0);
        chan_i    = 4'd4;
        in_valid  = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        vectors++;
        if (sat_cnt !== 16'd1) begin
            errors++; $display("FAIL mid_precnt: got %0d expected 1", sat_cnt);
        end
        nrst = 1'b0;
        #1;
        vectors += 3;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_valid: got %b expected 0", out_valid);
        end
        if (sat_cnt !== 16'd0) begin
            errors++; $display("FAIL mid_satcnt: got %0d expected 0", sat_cnt);
        end
        if (y_o !== 32'h0) begin
            errors++; $display("FAIL mid_y: got %h expected 0", y_o);
        end
        sb.delete();
        for (int c = 0; c < NC; c++) begin
            m_scale[c] = 0;
            m_shift[c] = 0;
        end
        repeat (2) tick();
        nrst = 1'b1;
        tick();
        send1(pack4(1000, -1000, 77, -3), 4'd4, y, lat);
        vectors += 2;
        if (y !== 32'h0) begin
            errors++; $display("FAIL mid_scale0: got %h expected 0", y);
        end
        if (lat != 3) begin
            errors++; $display("FAIL mid_latency: got %0d expected 3", lat);
        end
        tick();
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            m_scale[c] = 0;
            m_shift[c] = 0;
        end
        test_reset();
        test_basic();
        test_saturation();
        test_sticky();
        test_channel_map();
        test_write_race();
        test_backpressure();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/output_scaler_pipe.md
Name: output_scaler_pipe

Overview:
- Pipelined, per-channel requantiser; successor to the single-scale combinational output scaler.
- Converts a vector of signed accumulator sums into saturated signed outputs. Each element uses its own multiplier/shift pair, looked up from a channel table.
- Has selectable rounding, a valid/ready handshake with backpressure, and a sticky saturation counter.
- Sits between the accumulator array and the output activation buffer.

Parameters:
- numElements, 4, elements per input vector.
- elementWidth, 20, signed input width.
- outputWidth, 8, signed output width.
- fixedPointBits, 16, fractional bits of the unsigned scale.
- shiftBits, 5, width of the extra right-shift field.
- numChannels, 16, depth of the scale/shift table (power of 2).
- satCntWidth, 16, width of the saturation counter.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  input accepted when in_valid & in_ready.
- wx_i  in  numElements*elementWidth  signed sums, packed.
- chan_i  in  $clog2(numChannels)  channel index of element 0.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream ready.
- y_o  out  numElements*outputWidth  signed saturated results.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  $clog2(numChannels)  table write address.
- cfg_scale  in  fixedPointBits  unsigned scale written.
- cfg_shift  in  shiftBits  extra shift written.
- cfg_round  in  1  quasi-static; 0 = truncate toward zero, 1 = round half away from zero.
- sat_clr  in  1  clear saturation counter.
- sat_cnt  out  satCntWidth  saturated-element count.

Behaviour:
- Reset (async, nrst low):
  - All stage valids, out_valid, y_o and sat_cnt go to 0.
  - All table entries go to scale=0, shift=0.
  - in_ready is 1 once reset is released.
- Pipeline:
  - Three register stages, S1 multiply, S2 round/shift, S3 saturate.
  - Global advance en = ~out_valid | out_ready; in_ready = en.
  - All stages shift together when en is high. Bubbles are not collapsed.
  - Latency is 3 cycles from accept to out_valid when out_ready is held high; throughput is 1 vector/cycle.
- Stall: while en is low, all stage registers, y_o and out_valid hold. Data is never dropped or duplicated.
- Channel mapping: element i uses table entry (chan_i + i) mod numChannels, read at accept time. The scale and shift are carried with the data through the pipe.
- Table write:
  - Takes effect from the next cycle.
  - A write in the same cycle as an accept of the same entry gives the accept the old value.
  - In-flight vectors are unaffected by writes.
- S1: mag = |wx|, computed as elementWidth+1 bits so that the most-negative input is exact. p = mag*scale, unsigned, elementWidth+1+fixedPointBits bits. The input sign is registered alongside p.
- S2 (s = fixedPointBits + shift):
  - Round mode 0: q = p >> s.
  - Round mode 1: q = (p + 2^(s-1)) >> s, computed without overflow.
  - If s is at least the width of p, q = 0 (mode 0), or q = 1 iff p >= 2^(s-1) (mode 1).
  - Negative inputs give result = -q, so results are symmetric about zero.
- S3 saturation:
  - Result > 2^(outputWidth-1)-1 → 0111..1.
  - Result < -2^(outputWidth-1) → 1000..0.
  - Otherwise the low outputWidth bits are passed.
- Saturation counter:
  - Adds the number of saturated elements in each vector as it is loaded into S3 (on en & S2 valid).
  - Sticks at all-ones.
  - sat_clr takes priority: the count becomes 0 that cycle and that cycle's saturations are discarded.
- Input 0 gives output 0 in both rounding modes.

Optional Feature:
- Macro: OSCALER_ZERO_POINT_EN.
- When defined:
  - Extra port cfg_zp (in, outputWidth, signed) and an extra zp field per table entry, written with cfg_we; reset value 0.
  - In S3, zp is added to the signed result before saturation, in full width with no intermediate wrap.
- When undefined: no port and no field; behaviour is as described above, with latency unchanged.

Test Plan:
- Basic scaling: table[0] = scale 0x8000, shift 1, round 0; wx=100 → y=25; wx=-102 → y=-25; with round 1, wx=-102 → y=-26; out_valid rises exactly 3 cycles after accept.
- Saturation: scale 0xFFFF, shift 0; wx={1000,-1000,5,-5} → y={127,-128,4,-4}; sat_cnt=2; a second identical vector gives sat_cnt=4; sat_clr in the same cycle as the next saturating load → sat_cnt=0.
- Channel mapping: distinct scales in entries 14, 15, 0, 1; chan_i=14 → elements 0–3 use entries 14, 15, 0, 1 (wrap-around).
- Backpressure: stream 10 vectors with random in_valid and out_ready toggling → output sequence equals the input sequence in order; y_o is stable while out_valid & ~out_ready.
- Write/accept race: cfg_we to entry 3 in the same cycle as an accept with chan_i=3 → that vector uses the old scale; the next vector uses the new one.
- Reset mid-stream: assert nrst low with 3 vectors in flight → out_valid=0 and sat_cnt=0 immediately; scale 0 gives y=0 after release.
